// File: rtl/aerout_axis_tx.sv
// AER output port to AXI-Stream bridge: 4-phase handshake with the core, spike
// addresses buffered in a show-ahead FIFO, plus a saturating accepted-event count.
module aerout_axis_tx #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDR_W-1:0]        AEROUT_ADDR,
    input  logic                     AEROUT_REQ,
    output logic                     AEROUT_ACK,
    output logic [ADDR_W-1:0]        m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         event_count
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACKED = 1'b1;

    localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [0:0]        r_state;
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_cnt;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // Full is judged on the registered pointers, so a same-cycle pop cannot free a slot for a push.
    assign w_push = (r_state == ST_IDLE) && AEROUT_REQ && !w_full;
    assign w_pop  = !w_empty && m_axis_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_push)      r_state <= ST_ACKED;
                ST_ACKED: if (!AEROUT_REQ) r_state <= ST_IDLE;
                default:                   r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (r_cnt != '1) r_cnt <= r_cnt + CNT_ONE;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= AEROUT_ADDR;
    end

    assign AEROUT_ACK    = (r_state == ST_ACKED);
    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = r_mem[r_rd_ptr[AW-1:0]];
    assign fifo_level    = r_wr_ptr - r_rd_ptr;
    assign event_count   = r_cnt;

endmodule

// File: tb/tb_aerout_axis_tx.sv
// Self-checking bench for aerout_axis_tx: fixed vector table, directed corner
// sequences and random streaming, all compared against a queue-based reference model.
module tb_aerout_axis_tx;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] AEROUT_ADDR = '0;
    logic              AEROUT_REQ = 1'b0;
    logic              AEROUT_ACK;
    logic [ADDR_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic [4:0]        fifo_level;
    logic [CNT_W-1:0]  event_count;

    aerout_axis_tx #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .AEROUT_ADDR   (AEROUT_ADDR),
        .AEROUT_REQ    (AEROUT_REQ),
        .AEROUT_ACK    (AEROUT_ACK),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .fifo_level    (fifo_level),
        .event_count   (event_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: FIFO contents as a queue, handshake as a single flag.
    logic [7:0] m_q[$];
    bit         m_ack = 0;
    int         m_cnt = 0;
    logic [7:0] sent[$];
    logic [7:0] rcvd[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ack = 0;
        m_cnt = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".ack"},   32'(AEROUT_ACK),    32'(m_ack));
        chk({tag, ".valid"}, 32'(m_axis_tvalid), 32'(m_q.size() != 0));
        chk({tag, ".level"}, 32'(fifo_level),    32'(m_q.size()));
        chk({tag, ".count"}, 32'(event_count),   32'(m_cnt));
        if (m_q.size() != 0) chk({tag, ".data"}, 32'(m_axis_tdata), 32'(m_q[0]));
    endtask

    // One clock: drive at negedge, advance the model, compare 1 time unit after the rising edge.
    task automatic step(input logic req, input logic [7:0] addr, input logic tr);
        bit push, pop;
        @(negedge clk);
        AEROUT_REQ    = req;
        AEROUT_ADDR   = addr;
        m_axis_tready = tr;
        #1;
        if (m_axis_tvalid && tr) rcvd.push_back(m_axis_tdata);
        push = !m_ack && req && (m_q.size() < DEPTH);
        pop  = (m_q.size() != 0) && tr;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back(addr);
            sent.push_back(addr);
            if (m_cnt < CNT_MAX) m_cnt++;
            m_ack = 1;
        end else if (m_ack && !req) begin
            m_ack = 0;
        end
        @(posedge clk);
        #1;
        check_model("model");
    endtask

    function automatic logic pick_ready(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic aer_event(input logic [7:0] a, input int mode);
        int n = 0;
        do begin
            step(1'b1, a, pick_ready(mode));
            n++;
        end while (!m_ack && n < 200);
        if (!m_ack) begin
            n_err++;
            $display("FAIL ack_timeout: addr 0x%0h not acknowledged, expected ack within 200 cycles", a);
        end
        step(1'b0, a, pick_ready(mode));
    endtask

    task automatic drain();
        int n = 0;
        while (m_q.size() != 0 && n < 200) begin
            step(1'b0, 8'h00, 1'b1);
            n++;
        end
        chk("drain.level", 32'(fifo_level), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        AEROUT_REQ = 1'b0;
        m_axis_tready = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       req;
        logic [7:0] addr;
        logic       tr;
        logic       ack;
        logic       valid;
        logic [4:0] lvl;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{req:1'b1, addr:8'h2A, tr:1'b1, ack:1'b1, valid:1'b1, lvl:5'd1, cnt:4'd1};
        vecs[1] = '{req:1'b1, addr:8'h2A, tr:1'b1, ack:1'b1, valid:1'b0, lvl:5'd0, cnt:4'd1};
        vecs[2] = '{req:1'b0, addr:8'h00, tr:1'b1, ack:1'b0, valid:1'b0, lvl:5'd0, cnt:4'd1};
        vecs[3] = '{req:1'b0, addr:8'h00, tr:1'b1, ack:1'b0, valid:1'b0, lvl:5'd0, cnt:4'd1};

        // Reset state
        do_reset();
        #1;
        chk("reset.ack",   32'(AEROUT_ACK),    32'd0);
        chk("reset.valid", 32'(m_axis_tvalid), 32'd0);
        chk("reset.level", 32'(fifo_level),    32'd0);
        chk("reset.count", 32'(event_count),   32'd0);

        // Single event via vector table
        for (int i = 0; i < 4; i++) begin
            step(vecs[i].req, vecs[i].addr, vecs[i].tr);
            chk($sformatf("vec%0d.ack", i),   32'(AEROUT_ACK),    32'(vecs[i].ack));
            chk($sformatf("vec%0d.valid", i), 32'(m_axis_tvalid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d.level", i), 32'(fifo_level),    32'(vecs[i].lvl));
            chk($sformatf("vec%0d.count", i), 32'(event_count),   32'(vecs[i].cnt));
            if (vecs[i].valid) chk($sformatf("vec%0d.data", i), 32'(m_axis_tdata), 32'h2A);
        end

        // Backpressure fill: 16 accepted, 17th held
        do_reset();
        sent.delete();
        rcvd.delete();
        for (int i = 0; i < 16; i++) aer_event(8'(i), 0);
        chk("fill.level", 32'(fifo_level), 32'd16);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h10, 1'b0);
            chk("fill.held_ack", 32'(AEROUT_ACK),   32'd0);
            chk("fill.tdata",    32'(m_axis_tdata), 32'h00);
        end
        step(1'b1, 8'h10, 1'b1);
        chk("fill.defer_ack", 32'(AEROUT_ACK), 32'd0);
        chk("fill.defer_lvl", 32'(fifo_level), 32'd15);
        step(1'b1, 8'h10, 1'b1);
        chk("fill.late_ack", 32'(AEROUT_ACK), 32'd1);
        chk("fill.late_lvl", 32'(fifo_level), 32'd15);
        step(1'b0, 8'h00, 1'b1);
        drain();
        chk("fill.rx_count", 32'(rcvd.size()), 32'd17);
        for (int i = 0; i < rcvd.size() && i < 17; i++)
            chk($sformatf("fill.rx%0d", i), 32'(rcvd[i]), 32'(i));

        // Simultaneous push/pop at level 3
        do_reset();
        for (int i = 0; i < 3; i++) aer_event(8'h40 + 8'(i), 0);
        chk("pp3.pre_level", 32'(fifo_level), 32'd3);
        step(1'b1, 8'h43, 1'b1);
        chk("pp3.level", 32'(fifo_level),   32'd3);
        chk("pp3.ack",   32'(AEROUT_ACK),   32'd1);
        chk("pp3.head",  32'(m_axis_tdata), 32'h41);
        step(1'b0, 8'h00, 1'b0);
        drain();

        // Random streaming across several pointer wraps
        do_reset();
        sent.delete();
        rcvd.delete();
        for (int i = 0; i < 40; i++) begin
            aer_event(8'($urandom), 2);
            if ($urandom_range(0, 3) == 0) step(1'b0, 8'h00, pick_ready(2));
        end
        drain();
        chk("wrap.sent", 32'(sent.size()), 32'd40);
        chk("wrap.rcvd", 32'(rcvd.size()), 32'd40);
        for (int i = 0; i < 40 && i < rcvd.size() && i < sent.size(); i++)
            chk($sformatf("wrap.rx%0d", i), 32'(rcvd[i]), 32'(sent[i]));

        // Reset mid-operation with level 5 and ACK high
        do_reset();
        for (int i = 0; i < 4; i++) aer_event(8'h80 + 8'(i), 0);
        step(1'b1, 8'h84, 1'b0);
        chk("mid.pre_level", 32'(fifo_level), 32'd5);
        chk("mid.pre_ack",   32'(AEROUT_ACK), 32'd1);
        #2;
        rst_n = 1'b0;
        AEROUT_REQ = 1'b0;
        model_reset();
        #1;
        chk("mid.ack",   32'(AEROUT_ACK),    32'd0);
        chk("mid.valid", 32'(m_axis_tvalid), 32'd0);
        chk("mid.level", 32'(fifo_level),    32'd0);
        chk("mid.count", 32'(event_count),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        aer_event(8'h5A, 1);
        chk("mid.after_count", 32'(event_count), 32'd1);
        drain();

        // Counter saturation
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            aer_event(8'(i), 1);
            chk($sformatf("sat.count%0d", i), 32'(event_count), 32'(i < CNT_MAX ? i : CNT_MAX));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/aerout_axis_tx.md
# aerout_axis_tx

Output-event bridge between the tinyODIN AER output port and the UART transmitter's AXI-Stream input. It completes the 4-phase AER handshake with the core, buffers each spike address in a small FIFO, and presents the addresses one byte per beat on an AXI-Stream master. Output spikes are therefore no longer lost or stalled while the UART is mid-byte. It also keeps a saturating count of accepted events for debug LEDs and readback.

## Interface
- ADDR_W, 8, AER address width; also the AXI-Stream tdata width.
- DEPTH, 16, FIFO entries; must be a power of 2, at least 2.
- CNT_W, 16, width of the accepted-event counter.

- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- AEROUT_ADDR  in  ADDR_W  spike address from the core; valid while AEROUT_REQ=1.
- AEROUT_REQ  in  1  4-phase request from the core.
- AEROUT_ACK  out  1  4-phase acknowledge to the core.
- m_axis_tdata  out  ADDR_W  head-of-FIFO address.
- m_axis_tvalid  out  1  FIFO non-empty.
- m_axis_tready  in  1  UART TX ready.
- fifo_level  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- event_count  out  CNT_W  accepted AER events; saturates at all-ones.

## Operation
- The AER side is a 2-state FSM.
  - IDLE: AEROUT_ACK=0. If AEROUT_REQ=1 and the FIFO is not full, write AEROUT_ADDR into the FIFO, increment event_count (saturating) and go to ACKED.
  - ACKED: AEROUT_ACK=1. When AEROUT_REQ=0, go to IDLE.
- Full FIFO: stay in IDLE with ACK low and REQ left pending. The FIFO never overflows and no event is dropped.
- "Full" is evaluated before any pop in the same cycle. A pop coincident with a full FIFO does not allow a push in that cycle; the push happens the next cycle.
- FIFO pointers are ADDR bits plus one wrap bit, where ADDR bits = $clog2(DEPTH).
  - empty = pointers equal.
  - full = low bits equal and wrap bits differ.
  - fifo_level = wr_ptr − rd_ptr, modulo 2·DEPTH.
- AXI side uses a show-ahead FIFO.
  - m_axis_tvalid = !empty.
  - m_axis_tdata = mem[rd_ptr].
  - A pop occurs on tvalid && tready.
- A push and a pop in the same cycle, on a non-full, non-empty FIFO, leave fifo_level unchanged.
- Ordering is strict FIFO: AXI beats appear in AER acceptance order.
- event_count counts pushes only, not pops. It holds at 2^CNT_W−1 once reached.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - FSM to IDLE, AEROUT_ACK=0;
  - pointers to 0, m_axis_tvalid=0, fifo_level=0;
  - event_count=0.
  - m_axis_tdata is don't-care.
- Reset release is used synchronously: the first possible push is at the first rising edge with rst_n=1.
- Acceptance latency: REQ=1 sampled at edge E with FIFO not full gives ACK=1 and the push both registered at E, so ACK is visible in the cycle after E.
- Release: REQ=0 sampled at edge F gives ACK=0 after F. A new REQ is sampled no earlier than edge F+1.
- Minimum AER cycle is 2 clocks per event: 1 in IDLE accepting, 1+ in ACKED.
- Push to tvalid: a push at edge E into an empty FIFO gives tvalid=1 after E, with tdata equal to the pushed address.
- AXI rules:
  - tdata is stable while tvalid && !tready.
  - tvalid never drops without a pop.
  - One beat per cycle maximum.
- fifo_level and event_count are registered and update at the same edge as the push or pop.
- Reset mid-handshake (ACK=1 or REQ pending): state clears immediately and buffered entries are discarded. After release the core must re-present REQ from a low level. A REQ still high after release is treated as a new event.

## Test plan
- Single event: with tready=1, REQ and ADDR=0x2A are asserted. Required: ACK rises 1 cycle later; one beat tdata=0x2A, tvalid high for exactly 1 cycle; event_count=1; fifo_level returns to 0.
- Backpressure fill: with tready=0, 17 events 0x00..0x10 are presented at DEPTH=16. Required:
  - 16 are ACKed and fifo_level=16;
  - the 17th REQ is held with ACK=0 and tdata=0x00 stable.
  - Then tready=1. Required: the 17th is ACKed within 2 cycles; beats 0x00..0x10 arrive in order; final fifo_level=0.
- Simultaneous push/pop: at level 3, an event and a tready pop coincide. Required: level stays 3 and order is preserved. At level 16, a pop plus REQ in the same cycle: push is deferred exactly 1 cycle.
- Wrap-around: 40 events are streamed with random tready (50%). Required: all 40 addresses are received in order, with no duplicates or loss across 2+ pointer wraps.
- Reset mid-operation: with fifo_level=5 and ACK=1, rst_n is pulsed low for 1 cycle. Required, immediately: ACK=0, tvalid=0, fifo_level=0, event_count=0. After release, a fresh event flows normally.
- Counter saturation: with CNT_W=4, 20 events are sent. Required: event_count=15 after the 15th event and held at 15 through the 20th.
